ps2_key_ctrl: RTL and testbench

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// Generic first-word-fall-through FIFO, head visible one cycle after push into empty.
// Latency: push at edge N -> head_vld in cycle N+1.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
module fifo_fwft #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic             drop
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop & head_vld;
    // A pop frees the slot in the same edge, so a push onto a full FIFO is still taken.
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext,rel,code} events queued for the CPU.
// Latency: byte accepted in cycle N is at the FIFO head in cycle N+1; irq follows one cycle later.
// Backpressure: none toward the receiver; events arriving on a full queue are dropped and set overflow.
module ps2_key_ctrl #(
    parameter int DEPTH_LOG2   = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxReady,
    input  logic       rxError,
    input  logic       rdStrobe,
    input  logic       clrStatus,
    input  logic       irqEn,
    output logic [7:0] keyCode,
    output logic       keyRelease,
    output logic       keyExtended,
    output logic       keyValid,
    output logic       irq,
    output logic       overflow,
    output logic       errFlag
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXT    = 2'd1;
    localparam logic [1:0] BRK    = 2'd2;
    localparam logic [1:0] EXTBRK = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [TIMEOUT_BITS-1:0] tmo_cnt;
    logic                    rx_ready_q;
    logic                    armed;
    logic                    accept;
    logic                    tmo_fire;
    logic                    push;
    logic                    push_ext;
    logic                    push_rel;
    logic                    drop;
    logic [9:0]              head_dat;
    logic                    is_e0;
    logic                    is_f0;

    // armed stays low after reset until rxReady is seen low, so a level left high across reset is ignored.
    assign accept = rxReady & ~rx_ready_q & armed & ~rxError;
    assign is_e0  = (rxData == 8'hE0);
    assign is_f0  = (rxData == 8'hF0);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_rel  = 1'b0;
        tmo_fire  = 1'b0;
        if (rxError) begin
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (is_e0)      state_nxt = EXT;
                    else if (is_f0) state_nxt = BRK;
                    else            push      = 1'b1;
                end
                EXT: begin
                    if (is_f0)      state_nxt = EXTBRK;
                    else if (!is_e0) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (!is_e0 && !is_f0) begin
                        push      = 1'b1;
                        push_rel  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    if (!is_e0 && !is_f0) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        push_rel  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE && (&tmo_cnt)) begin
            tmo_fire  = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            rx_ready_q <= 1'b0;
            armed      <= 1'b0;
            overflow   <= 1'b0;
            errFlag    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_ready_q <= rxReady;
            if (!rxReady)
                armed <= 1'b1;
            if (accept || rxError || tmo_fire || state == IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (clrStatus)
                overflow <= 1'b0;
            if (rxError || tmo_fire)
                errFlag <= 1'b1;
            else if (clrStatus)
                errFlag <= 1'b0;
            irq <= irqEn & keyValid;
        end
    end

    fifo_fwft #(
        .WIDTH      (10),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({push_ext, push_rel, rxData}),
        .pop      (rdStrobe),
        .head_dat (head_dat),
        .head_vld (keyValid),
        .drop     (drop)
    );

    assign keyExtended = head_dat[9];
    assign keyRelease  = head_dat[8];
    assign keyCode     = head_dat[7:0];
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed scenarios plus randomized traffic, every cycle compared against a queue-based event model.
module tb_ps2_key_ctrl;
    localparam int DEPTH   = 4;
    localparam int TMO_LEN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxReady = 1'b0;
    logic       rxError = 1'b0;
    logic       rdStrobe = 1'b0;
    logic       clrStatus = 1'b0;
    logic       irqEn = 1'b0;
    logic [7:0] keyCode;
    logic       keyRelease;
    logic       keyExtended;
    logic       keyValid;
    logic       irq;
    logic       overflow;
    logic       errFlag;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [9:0] mq[$];
    bit m_ext, m_brk, m_seen_low, m_prev_rdy, m_ovf, m_err, m_irq;
    int edge_cnt = 0;
    int last_acc = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.DEPTH_LOG2(2), .TIMEOUT_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxData      (rxData),
        .rxReady     (rxReady),
        .rxError     (rxError),
        .rdStrobe    (rdStrobe),
        .clrStatus   (clrStatus),
        .irqEn       (irqEn),
        .keyCode     (keyCode),
        .keyRelease  (keyRelease),
        .keyExtended (keyExtended),
        .keyValid    (keyValid),
        .irq         (irq),
        .overflow    (overflow),
        .errFlag     (errFlag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop_ok, acc, do_push, err_set, ovf_set;
        logic [9:0] ent;
        int sz;
        edge_cnt++;
        if (reset) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_seen_low = 0; m_prev_rdy = 0;
            m_ovf = 0; m_err = 0; m_irq = 0;
            return;
        end
        sz = mq.size();
        pop_ok = rdStrobe && sz > 0;
        acc = rxReady && !m_prev_rdy && m_seen_low && !rxError;
        do_push = 0; err_set = rxError; ovf_set = 0; ent = '0;
        if (rxError) begin
            m_ext = 0; m_brk = 0;
        end else if (acc) begin
            last_acc = edge_cnt;
            if (rxData == 8'hE0) begin
                if (!m_brk) m_ext = 1;
            end else if (rxData == 8'hF0) begin
                m_brk = 1;
            end else begin
                ent = {m_ext, m_brk, rxData};
                do_push = 1;
                m_ext = 0; m_brk = 0;
            end
        end else if ((m_ext || m_brk) && (edge_cnt - last_acc) >= TMO_LEN) begin
            m_ext = 0; m_brk = 0; err_set = 1;
        end
        m_irq = irqEn && sz > 0;
        if (pop_ok) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(ent);
            else ovf_set = 1;
        end
        if (err_set) m_err = 1; else if (clrStatus) m_err = 0;
        if (ovf_set) m_ovf = 1; else if (clrStatus) m_ovf = 0;
        m_prev_rdy = rxReady;
        if (!rxReady) m_seen_low = 1;
    endtask

    task automatic compare_all();
        chk("keyValid", keyValid, mq.size() > 0);
        chk("irq", irq, m_irq);
        chk("overflow", overflow, m_ovf);
        chk("errFlag", errFlag, m_err);
        if (mq.size() > 0)
            chk("head", {keyExtended, keyRelease, keyCode}, mq[0]);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [7:0] b);
        rxReady = 1'b0;
        cyc();
        rxData = b;
        rxReady = 1'b1;
        cyc();
    endtask

    task automatic pop();
        rdStrobe = 1'b1;
        cyc();
        rdStrobe = 1'b0;
    endtask

    task automatic clr();
        clrStatus = 1'b1;
        cyc();
        clrStatus = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        @(negedge clk);
        idle(2);
        reset = 1'b0;
        chk("rst_keyValid", keyValid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_errFlag", errFlag, 0);

        // single make code
        send(8'h1C);
        chk("make_valid", keyValid, 1);
        chk("make_entry", {keyExtended, keyRelease, keyCode}, 10'h01C);
        pop();
        chk("make_popped", keyValid, 0);

        // extended break, then plain break
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(2);
        chk("extbrk_count", mq.size(), 1);
        chk("extbrk_entry", {keyExtended, keyRelease, keyCode}, 10'h375);
        pop();
        send(8'hF0); send(8'h1C);
        chk("brk_entry", {keyExtended, keyRelease, keyCode}, 10'h11C);
        pop();

        // overflow on fifth push
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("ovf_set", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", keyCode, i);
            pop();
        end
        chk("ovf_drained", keyValid, 0);
        clr();
        chk("ovf_clr", overflow, 0);

        // prefix timeout
        send(8'hE0);
        idle(20);
        chk("tmo_err", errFlag, 1);
        send(8'h1C);
        chk("tmo_entry", {keyExtended, keyRelease, keyCode}, 10'h01C);
        pop();
        clr();

        // held rxReady yields one accept
        rxReady = 1'b0; cyc();
        rxData = 8'h2A; rxReady = 1'b1;
        idle(20);
        chk("held_count", mq.size(), 1);
        chk("held_entry", keyCode, 8'h2A);
        pop();

        // rxError aborts a break prefix
        send(8'hF0);
        rxError = 1'b1; cyc(); rxError = 1'b0;
        send(8'h1C);
        chk("rxerr_entry", {keyExtended, keyRelease, keyCode}, 10'h01C);
        chk("rxerr_flag", errFlag, 1);
        pop();
        clr();

        // irq timing
        irqEn = 1'b1;
        send(8'h33);
        chk("irq_lag", irq, 0);
        cyc();
        chk("irq_set", irq, 1);
        pop();
        cyc();
        chk("irq_clear", irq, 0);

        // reset mid-prefix, rxReady left high across release
        send(8'hE0);
        do_reset();
        idle(3);
        chk("rst_held_ready", keyValid, 0);
        send(8'h1C);
        chk("rst_prefix_entry", {keyExtended, keyRelease, keyCode}, 10'h01C);
        pop();

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            rdStrobe  = ($urandom_range(0, 2) == 0);
            clrStatus = ($urandom_range(0, 7) == 0);
            rxError   = ($urandom_range(0, 40) == 0);
            irqEn     = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                case ($urandom_range(0, 9))
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                send(b);
            end else if (r == 6) begin
                idle(1);
            end else if (r == 7) begin
                idle(($urandom_range(0, 3) == 0) ? 25 : 2);
            end else if (r == 8) begin
                if ($urandom_range(0, 3) == 0) do_reset(); else idle(1);
            end else begin
                idle(3);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
